dcnn_mch_rfifo: RTL and testbench
=================================

Name: dcnn_mch_rfifo

Overview:
Parametrised N-channel ready/valid stream buffer; successor to the per-channel stdcore_rfifo instances feeding dcnn_top's odd/even fin ports and kernel port.
- One independent FIFO per channel; per-channel level and almost-full reporting; synchronous flush.
- Gang mode presents all channels in lockstep, so odd/even fin words are popped together.
- Sits between DRAM read DMA (producer) and the dcnn_top fin/kernel inputs (consumer).

Parameters:
- DW, 16, data width per channel
- NCH, 2, channel count (1..16)
- DEPTH, 256, entries per channel; power of two, >=2
- AW, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all channels
- gang_en  in  1  1 = lockstep consumer mode
- afull_thr  in  AW+1  almost-full threshold, shared by all channels
- p_data  in  NCH*DW  producer data; channel i at [i*DW +: DW]
- p_val  in  NCH  producer valid per channel
- p_rdy  out  NCH  producer ready per channel
- c_data  out  NCH*DW  consumer data (head entry)
- c_val  out  NCH  consumer valid per channel
- c_rdy  in  NCH  consumer ready per channel
- level  out  NCH*(AW+1)  per-channel occupancy, 0..DEPTH
- afull  out  NCH  level >= afull_thr
- peak  out  NCH*(AW+1)  watermark (see Optional Feature)

Behaviour:
Reset (arst_n low, async):
- Pointers and counts = 0.
- p_rdy = all 1s; c_val = 0; level = 0; afull = (afull_thr == 0).
- c_data undefined (X allowed); peak = 0.

Per channel i:
- push_i = p_val[i] & p_rdy[i]; p_rdy[i] = (count_i != DEPTH). p_rdy is registered-state-only, with no combinational path from p_val.
- Storage is first-word-fall-through. c_data shows the head entry combinationally from RAM/registers.
- Latency: word pushed at edge t gives c_val high from edge t+1; minimum 1 cycle.
- Independent mode (gang_en=0): c_val[i] = (count_i != 0); pop_i = c_val[i] & c_rdy[i].
- Gang mode (gang_en=1): c_val[i] = &(count_j != 0) over all j, identical on every bit.
  - pop_all = c_val[0] & c_rdy[0]; c_rdy[1..NCH-1] are ignored.
  - Pushes stay independent per channel.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. Legal when full (pop frees; p_rdy was low, so no push occurs) and when empty (no pop, since c_val is low).
- Pointers wrap modulo DEPTH.
- count and level are AW+1 bits, saturating logically at DEPTH, which the handshake guarantees.
- afull[i] = (count_i >= afull_thr); registered-count based, no extra latency.
- flush: at the next edge, all pointers/counts = 0. Flush has priority over push and pop; the same-cycle push is discarded and the pop is not counted.
  - p_rdy stays high during flush, since it reflects count.
  - c_val = 0 in the cycle after flush.
- gang_en toggling: takes effect combinationally. No data is lost or duplicated. Changing it with partially filled channels is legal.
- No state machine beyond per-channel pointer/count registers; no internal arbitration.

Optional Feature:
- Macro: DCNN_RFIFO_WATERMARK_EN.
- Defined: per-channel peak register. peak_i <= max(peak_i, count_i_next) each edge; cleared by reset and flush.
- Undefined: peak tied to 0 and no registers are inferred. The port always exists.

Decomposition:
- Package dcnn_fifo_pkg: function clog2_f; localparam MAX_NCH = 16; typedef for the level word (logic [AW:0] via a parameterised struct helper); flattened-slice macros/functions for `[i*DW +: DW]`.
- Sub-module dcnn_rfifo_ch: single-channel FIFO with count, afull, flush, watermark and an external pop_en input. The top instantiates NCH copies in a generate loop and forms the gang c_val/pop logic.

Test Plan:
1. NCH=2, DEPTH=8, gang_en=0: push 1..8 on ch0 with c_rdy=0 -> p_rdy[0]=0 after 8th push, level[0]=8; ch1 unaffected, p_rdy[1]=1, c_val[1]=0.
2. Full ch0 with simultaneous p_val=1,c_rdy=1 -> pops 1, no push that cycle; next cycle p_rdy=1, level=7; drain order 1..8 exactly.
3. Gang: ch0 holds 3 words, ch1 holds 0 -> c_val=2'b00; push 1 word to ch1 -> c_val=2'b11 next cycle; one pop with c_rdy=2'b01 -> level = {0,2}.
4. Latency/wrap: stream 20 words with c_rdy=1 continuously -> first c_val one cycle after first push, output equals input 1..20, level never exceeds 1.
5. afull_thr=6: push 6 -> afull rises on the edge of the 6th push; pop 1 -> afull falls.
6. flush asserted with push and pop on level=5 -> next cycle level=0, c_val=0, pushed word absent. With DCNN_RFIFO_WATERMARK_EN: peak=5 before flush, 0 after. arst_n pulsed mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dcnn_fifo_pkg.sv
// dcnn_fifo_pkg: shared limits, width helpers and the flattened-slice macro for the rfifo blocks.
`ifndef DCNN_FIFO_PKG_SV
`define DCNN_FIFO_PKG_SV
`define DCNN_SLICE(i, w) (i)*(w) +: (w)
package dcnn_fifo_pkg;
    localparam int MAX_NCH = 16;

    function automatic int clog2_f(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lvl_w(input int depth);
        return clog2_f(depth) + 1;
    endfunction
endpackage
`endif

// File: rtl/dcnn_rfifo_ch.sv
// dcnn_rfifo_ch: single-channel first-word-fall-through FIFO with count, afull, flush and pop_en.
// Peak watermark register present only when DCNN_RFIFO_WATERMARK_EN is defined.
module dcnn_rfifo_ch
    import dcnn_fifo_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int AW    = clog2_f(DEPTH)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          flush,
    input  logic [AW:0]   afull_thr,
    input  logic [DW-1:0] p_data,
    input  logic          p_val,
    output logic          p_rdy,
    output logic [DW-1:0] c_data,
    output logic          nempty,
    input  logic          pop_en,
    output logic [AW:0]   level,
    output logic          afull,
    output logic [AW:0]   peak
);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign p_rdy  = cnt_q != FULL;
    assign nempty = cnt_q != '0;
    assign push   = p_val & p_rdy;
    assign pop    = pop_en & nempty;
    assign c_data = mem_q[rp_q];
    assign level  = cnt_q;
    assign afull  = cnt_q >= afull_thr;

    always_comb begin
        wp_d  = flush ? '0 : push ? wp_q + PONE : wp_q;
        rp_d  = flush ? '0 : pop ? rp_q + PONE : rp_q;
        cnt_d = flush ? '0 : (push && !pop) ? cnt_q + ONE : (pop && !push) ? cnt_q - ONE : cnt_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; head contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wp_q] <= p_data;
    end

`ifdef DCNN_RFIFO_WATERMARK_EN
    logic [AW:0] peak_q, peak_d;
    always_comb begin
        peak_d = flush ? '0 : (cnt_d > peak_q) ? cnt_d : peak_q;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) peak_q <= '0;
        else         peak_q <= peak_d;
    end
    assign peak = peak_q;
`else
    assign peak = '0;
`endif
endmodule

// File: rtl/dcnn_mch_rfifo.sv
// dcnn_mch_rfifo: N-channel ready/valid stream buffer with per-channel FIFOs and lockstep gang mode.
// Optional peak watermark per channel via DCNN_RFIFO_WATERMARK_EN (peak reads 0 otherwise).
module dcnn_mch_rfifo
    import dcnn_fifo_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 256,
    parameter int AW    = clog2_f(DEPTH)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                flush,
    input  logic                gang_en,
    input  logic [AW:0]         afull_thr,
    input  logic [NCH*DW-1:0]   p_data,
    input  logic [NCH-1:0]      p_val,
    output logic [NCH-1:0]      p_rdy,
    output logic [NCH*DW-1:0]   c_data,
    output logic [NCH-1:0]      c_val,
    input  logic [NCH-1:0]      c_rdy,
    output logic [NCH*(AW+1)-1:0] level,
    output logic [NCH-1:0]      afull,
    output logic [NCH*(AW+1)-1:0] peak
);
    logic [NCH-1:0] nempty, pop;
    logic           all_ne;

    if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
        $error("dcnn_mch_rfifo: NCH out of range");
    end

    // Gang mode: every channel presents valid only when all hold data, and channel 0's ready pops all.
    assign all_ne = &nempty;
    assign c_val  = gang_en ? {NCH{all_ne}} : nempty;
    assign pop    = gang_en ? {NCH{all_ne & c_rdy[0]}} : nempty & c_rdy;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        dcnn_rfifo_ch #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ch (
            .clk       (clk),
            .arst_n    (arst_n),
            .flush     (flush),
            .afull_thr (afull_thr),
            .p_data    (p_data[`DCNN_SLICE(i, DW)]),
            .p_val     (p_val[i]),
            .p_rdy     (p_rdy[i]),
            .c_data    (c_data[`DCNN_SLICE(i, DW)]),
            .nempty    (nempty[i]),
            .pop_en    (pop[i]),
            .level     (level[`DCNN_SLICE(i, AW+1)]),
            .afull     (afull[i]),
            .peak      (peak[`DCNN_SLICE(i, AW+1)])
        );
    end
endmodule

// File: tb/tb_dcnn_mch_rfifo.sv
// tb_dcnn_mch_rfifo: scoreboard-based bench for dcnn_mch_rfifo (NCH=2, DEPTH=8, DW=16).
module tb_dcnn_mch_rfifo;
    logic        clk = 0, arst_n = 0, flush = 0, gang_en = 0;
    logic [3:0]  afull_thr = 4'd6;
    logic [31:0] p_data = '0, c_data;
    logic [1:0]  p_val = '0, p_rdy, c_val, c_rdy = '0, afull;
    logic [7:0]  level, peak;
    logic [15:0] q0[$], q1[$];
    logic [15:0] e0, e1;
    int total = 0, bad = 0;

    dcnn_mch_rfifo #(.DW(16), .NCH(2), .DEPTH(8)) dut (
        .clk(clk), .arst_n(arst_n), .flush(flush), .gang_en(gang_en), .afull_thr(afull_thr),
        .p_data(p_data), .p_val(p_val), .p_rdy(p_rdy), .c_data(c_data), .c_val(c_val),
        .c_rdy(c_rdy), .level(level), .afull(afull), .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ch(input int ch, input logic [15:0] v);
        p_val = '0;
        p_val[ch] = 1'b1;
        p_data[ch*16 +: 16] = v;
        if (ch == 0) q0.push_back(v); else q1.push_back(v);
        tick();
        p_val = '0;
    endtask

    task automatic test_reset();
        afull_thr = 4'd0;
        #3;
        total++; if (p_rdy !== 2'b11) begin bad++; $display("FAIL rst_p_rdy got %b exp 11", p_rdy); end
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL rst_c_val got %b exp 00", c_val); end
        total++; if (level !== 8'h00) begin bad++; $display("FAIL rst_level got %h exp 00", level); end
        total++; if (afull !== 2'b11) begin bad++; $display("FAIL rst_afull_thr0 got %b exp 11", afull); end
        total++; if (peak !== 8'h00) begin bad++; $display("FAIL rst_peak got %h exp 00", peak); end
        afull_thr = 4'd6;
        #1;
        total++; if (afull !== 2'b00) begin bad++; $display("FAIL rst_afull_thr6 got %b exp 00", afull); end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) push_ch(0, 16'(k));
        total++; if (p_rdy !== 2'b10) begin bad++; $display("FAIL fill_p_rdy got %b exp 10", p_rdy); end
        total++; if (level[3:0] !== 4'd8) begin bad++; $display("FAIL fill_level0 got %0d exp 8", level[3:0]); end
        total++; if (level[7:4] !== 4'd0) begin bad++; $display("FAIL fill_level1 got %0d exp 0", level[7:4]); end
        total++; if (c_val !== 2'b01) begin bad++; $display("FAIL fill_c_val got %b exp 01", c_val); end
    endtask

    task automatic test_full_pushpop();
        p_val = 2'b01;
        p_data[15:0] = 16'h0099;
        c_rdy = 2'b01;
        e0 = q0.pop_front();
        total++; if (c_data[15:0] !== e0) begin bad++; $display("FAIL full_pop_data got %h exp %h", c_data[15:0], e0); end
        tick();
        p_val = '0;
        c_rdy = '0;
        total++; if (p_rdy[0] !== 1'b1) begin bad++; $display("FAIL full_p_rdy got %b exp 1", p_rdy[0]); end
        total++; if (level[3:0] !== 4'd7) begin bad++; $display("FAIL full_level got %0d exp 7", level[3:0]); end
        c_rdy = 2'b01;
        while (q0.size() != 0) begin
            e0 = q0.pop_front();
            total++; if (c_val[0] !== 1'b1 || c_data[15:0] !== e0) begin bad++; $display("FAIL drain_data got v=%b d=%h exp v=1 d=%h", c_val[0], c_data[15:0], e0); end
            tick();
        end
        c_rdy = '0;
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL drain_empty got %b exp 00", c_val); end
    endtask

    task automatic test_gang();
        for (int k = 1; k <= 3; k++) push_ch(0, 16'(16'h30 + k));
        gang_en = 1'b1;
        #1;
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL gang_cval_partial got %b exp 00", c_val); end
        push_ch(1, 16'h0041);
        total++; if (c_val !== 2'b11) begin bad++; $display("FAIL gang_cval_all got %b exp 11", c_val); end
        c_rdy = 2'b10;
        tick();
        total++; if (level !== 8'h13) begin bad++; $display("FAIL gang_rdy1_ignored got %h exp 13", level); end
        c_rdy = 2'b01;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        total++; if (c_data !== {e1, e0}) begin bad++; $display("FAIL gang_pop_data got %h exp %h", c_data, {e1, e0}); end
        tick();
        c_rdy = '0;
        total++; if (level !== 8'h02) begin bad++; $display("FAIL gang_level got %h exp 02", level); end
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL gang_cval_after got %b exp 00", c_val); end
        gang_en = 1'b0;
        #1;
        total++; if (c_val !== 2'b01) begin bad++; $display("FAIL ungang_cval got %b exp 01", c_val); end
        c_rdy = 2'b01;
        while (q0.size() != 0) begin
            e0 = q0.pop_front();
            total++; if (c_data[15:0] !== e0) begin bad++; $display("FAIL ungang_drain got %h exp %h", c_data[15:0], e0); end
            tick();
        end
        c_rdy = '0;
    endtask

    task automatic test_stream();
        c_rdy = 2'b01;
        for (int k = 1; k <= 21; k++) begin
            if (q0.size() == 0) begin
                total++; if (c_val[0] !== 1'b0) begin bad++; $display("FAIL stream_lat got %b exp 0", c_val[0]); end
            end else begin
                e0 = q0.pop_front();
                total++; if (c_val[0] !== 1'b1 || c_data[15:0] !== e0) begin bad++; $display("FAIL stream_data got v=%b d=%h exp v=1 d=%h", c_val[0], c_data[15:0], e0); end
            end
            total++; if (level[3:0] > 4'd1) begin bad++; $display("FAIL stream_level got %0d exp <=1", level[3:0]); end
            if (k <= 20) push_ch(0, 16'(k)); else tick();
        end
        c_rdy = '0;
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL stream_end got %b exp 00", c_val); end
    endtask

    task automatic test_afull();
        afull_thr = 4'd6;
        for (int k = 1; k <= 5; k++) push_ch(0, 16'(16'h60 + k));
        total++; if (afull !== 2'b00) begin bad++; $display("FAIL afull_5 got %b exp 00", afull); end
        push_ch(0, 16'h0066);
        total++; if (afull !== 2'b01) begin bad++; $display("FAIL afull_6 got %b exp 01", afull); end
        c_rdy = 2'b01;
        while (q0.size() != 0) begin
            e0 = q0.pop_front();
            total++; if (c_data[15:0] !== e0) begin bad++; $display("FAIL afull_drain got %h exp %h", c_data[15:0], e0); end
            tick();
            if (q0.size() == 5) begin
                total++; if (afull[0] !== 1'b0) begin bad++; $display("FAIL afull_fall got %b exp 0", afull[0]); end
            end
        end
        c_rdy = '0;
    endtask

    task automatic test_async_reset();
        push_ch(0, 16'h0001);
        push_ch(0, 16'h0002);
        push_ch(1, 16'h0003);
        #2 arst_n = 1'b0;
        #1;
        total++; if (level !== 8'h00) begin bad++; $display("FAIL arst_level got %h exp 00", level); end
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL arst_c_val got %b exp 00", c_val); end
        total++; if (p_rdy !== 2'b11) begin bad++; $display("FAIL arst_p_rdy got %b exp 11", p_rdy); end
        total++; if (peak !== 8'h00) begin bad++; $display("FAIL arst_peak got %h exp 00", peak); end
        q0.delete();
        q1.delete();
        @(negedge clk);
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] pk;
`ifdef DCNN_RFIFO_WATERMARK_EN
        pk = 4'd5;
`else
        pk = 4'd0;
`endif
        for (int k = 1; k <= 5; k++) push_ch(0, 16'(16'h50 + k));
        total++; if (level[3:0] !== 4'd5) begin bad++; $display("FAIL flush_pre_level got %0d exp 5", level[3:0]); end
        total++; if (peak[3:0] !== pk) begin bad++; $display("FAIL flush_pre_peak got %0d exp %0d", peak[3:0], pk); end
        flush = 1'b1;
        p_val = 2'b01;
        p_data[15:0] = 16'h00EE;
        c_rdy = 2'b01;
        tick();
        flush = 1'b0;
        p_val = '0;
        c_rdy = '0;
        q0.delete();
        total++; if (level !== 8'h00) begin bad++; $display("FAIL flush_level got %h exp 00", level); end
        total++; if (c_val !== 2'b00) begin bad++; $display("FAIL flush_c_val got %b exp 00", c_val); end
        total++; if (p_rdy !== 2'b11) begin bad++; $display("FAIL flush_p_rdy got %b exp 11", p_rdy); end
        total++; if (peak !== 8'h00) begin bad++; $display("FAIL flush_peak got %h exp 00", peak); end
        push_ch(0, 16'h0077);
        e0 = q0.pop_front();
        total++; if (c_data[15:0] !== e0 || level[3:0] !== 4'd1) begin bad++; $display("FAIL flush_after got d=%h l=%0d exp d=%h l=1", c_data[15:0], level[3:0], e0); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pushpop();
        test_gang();
        test_stream();
        test_afull();
        test_async_reset();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
